// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response out.
// An optional timeout aborts a bus cycle whose slave never acknowledges.
module wb_cmd_master #(
    parameter int ADDR_WIDTH     = 1,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_writedata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_readdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] wbm_address,
    output logic [DATA_WIDTH-1:0] wbm_writedata,
    input  logic [DATA_WIDTH-1:0] wbm_readdata,
    output logic                  wbm_strobe,
    output logic                  wbm_write,
    output logic                  wbm_cycle,
    input  logic                  wbm_ack
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_error     <= 1'b0;
            rsp_readdata  <= '0;
            wbm_cycle     <= 1'b0;
            wbm_strobe    <= 1'b0;
            wbm_write     <= 1'b0;
            wbm_address   <= '0;
            wbm_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_address   <= cmd_address;
                        wbm_writedata <= cmd_writedata;
                        wbm_write     <= cmd_write;
                        wbm_cycle     <= 1'b1;
                        wbm_strobe    <= 1'b1;
                        cmd_ready     <= 1'b0;
                        count         <= '0;
                        state         <= BUS;
                    end
                end
                BUS: begin
                    // An ack on the same edge as the last allowed cycle still completes normally.
                    if (wbm_ack) begin
                        wbm_cycle    <= 1'b0;
                        wbm_strobe   <= 1'b0;
                        wbm_write    <= 1'b0;
                        rsp_readdata <= wbm_write ? '0 : wbm_readdata;
                        rsp_error    <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else if (TIMEOUT_EN && (count == CNT_LAST)) begin
                        wbm_cycle    <= 1'b0;
                        wbm_strobe   <= 1'b0;
                        wbm_write    <= 1'b0;
                        rsp_readdata <= '0;
                        rsp_error    <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else if (count != '1) begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master against a small Wishbone slave, with a transaction-level
// model checked every cycle plus hand-computed expectations per scenario.
module tb_wb_cmd_master;

    localparam int AW = 1;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_address = '0;
    logic [DW-1:0] cmd_writedata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_readdata;
    logic          rsp_error;
    logic [AW-1:0] wbm_address;
    logic [DW-1:0] wbm_writedata;
    logic [DW-1:0] wbm_readdata;
    logic          wbm_strobe;
    logic          wbm_write;
    logic          wbm_cycle;
    logic          wbm_ack;

    wb_cmd_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_address(cmd_address),
        .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_readdata(rsp_readdata),
        .rsp_error(rsp_error),
        .wbm_address(wbm_address),
        .wbm_writedata(wbm_writedata),
        .wbm_readdata(wbm_readdata),
        .wbm_strobe(wbm_strobe),
        .wbm_write(wbm_write),
        .wbm_cycle(wbm_cycle),
        .wbm_ack(wbm_ack)
    );

    always #5 clk = ~clk;

    // Slave: two registers, register 0 is the bar graph; ack after ack_lat bus cycles (0 = never).
    logic [DW-1:0] slv_mem [2];
    int unsigned   slv_cnt;
    int unsigned   ack_lat = 1;
    logic          stray_ack = 1'b0;
    logic [7:0]    bar_graph;

    assign wbm_ack = stray_ack |
                     (wbm_cycle & wbm_strobe & (ack_lat != 0) & (slv_cnt == ack_lat - 1));
    assign wbm_readdata = slv_mem[wbm_address];
    assign bar_graph = slv_mem[0][7:0];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            slv_mem[0] <= '0;
            slv_mem[1] <= 16'h1234;
            slv_cnt    <= 0;
        end else begin
            if (wbm_cycle && wbm_ack && wbm_write) slv_mem[wbm_address] <= wbm_writedata;
            if (wbm_cycle && !wbm_ack) slv_cnt <= slv_cnt + 1;
            else slv_cnt <= 0;
        end
    end

    int n_total = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_wait(input string name);
        n_total++;
        $display("FAIL %s: got no event expected one within the cycle budget", name);
    endtask

    // Transaction-level model: outstanding command, expected responses, model memory.
    typedef struct {
        logic [DW-1:0] rd;
        logic          er;
    } rsp_t;

    rsp_t          rsp_q[$];
    logic [DW-1:0] model_mem [2];
    bit            busy;
    bit            in_bus;
    int            bus_clks;
    logic          cur_w;
    logic [AW-1:0] cur_a;
    logic [DW-1:0] cur_d;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
                chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
                chk("rst_rsp_error", 32'(rsp_error), 32'(0));
                chk("rst_rsp_readdata", 32'(rsp_readdata), 32'(0));
                chk("rst_wbm_cycle", 32'(wbm_cycle), 32'(0));
                chk("rst_wbm_strobe", 32'(wbm_strobe), 32'(0));
                chk("rst_wbm_write", 32'(wbm_write), 32'(0));
                chk("rst_wbm_address", 32'(wbm_address), 32'(0));
                chk("rst_wbm_writedata", 32'(wbm_writedata), 32'(0));
                busy = 0;
                in_bus = 0;
                bus_clks = 0;
                rsp_q.delete();
                model_mem[0] = '0;
                model_mem[1] = 16'h1234;
            end else begin
                automatic bit was_busy = busy;
                chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
                chk("rsp_valid", 32'(rsp_valid), 32'(rsp_q.size() != 0));
                if (rsp_q.size() != 0) begin
                    chk("rsp_readdata", 32'(rsp_readdata), 32'(rsp_q[0].rd));
                    chk("rsp_error", 32'(rsp_error), 32'(rsp_q[0].er));
                    if (rsp_ready) begin
                        void'(rsp_q.pop_front());
                        busy = 0;
                    end
                end
                chk("wbm_cycle", 32'(wbm_cycle), 32'(in_bus));
                chk("wbm_strobe", 32'(wbm_strobe), 32'(in_bus));
                if (in_bus) begin
                    chk("wbm_address", 32'(wbm_address), 32'(cur_a));
                    chk("wbm_writedata", 32'(wbm_writedata), 32'(cur_d));
                    chk("wbm_write", 32'(wbm_write), 32'(cur_w));
                    bus_clks++;
                    if (wbm_ack) begin
                        if (cur_w) begin
                            model_mem[cur_a] = cur_d;
                            rsp_q.push_back('{rd: '0, er: 1'b0});
                        end else begin
                            rsp_q.push_back('{rd: model_mem[cur_a], er: 1'b0});
                        end
                        in_bus = 0;
                    end else if (TO != 0 && bus_clks == TO) begin
                        rsp_q.push_back('{rd: '0, er: 1'b1});
                        in_bus = 0;
                    end
                end else begin
                    chk("wbm_write_idle", 32'(wbm_write), 32'(0));
                end
                if (!was_busy && cmd_valid) begin
                    busy = 1;
                    in_bus = 1;
                    bus_clks = 0;
                    cur_w = cmd_write;
                    cur_a = cmd_address;
                    cur_d = cmd_writedata;
                end
            end
        end
    end

    // Cycle stamps of CYC rising edges and a running count of CYC-high cycles.
    int tcount = 0;
    int rise_t[$];
    int cyc_hi = 0;
    initial forever begin
        @(posedge clk);
        tcount++;
    end
    initial begin
        automatic logic prev_cyc = 1'b0;
        forever begin
            @(negedge clk);
            if (wbm_cycle && !prev_cyc) rise_t.push_back(tcount);
            if (wbm_cycle) cyc_hi++;
            prev_cyc = wbm_cycle;
        end
    end

    task automatic wait_accept(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        if (!ok) fail_wait(name);
        @(posedge clk);
    endtask

    task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int cyc_clks, output int lat, output logic [DW-1:0] rd,
                           output logic er, output logic [DW-1:0] wd_seen);
        bit ok;
        bit got = 0;
        cyc_clks = 0;
        lat = 0;
        rd = 'x;
        er = 1'bx;
        wd_seen = 'x;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_address = a;
        cmd_writedata = d;
        wait_accept("accept", ok);
        #1;
        cmd_valid = 1'b0;
        if (!ok) return;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (wbm_cycle) begin
                cyc_clks++;
                wd_seen = wbm_writedata;
            end
            if (rsp_valid) begin
                got = 1;
                rd = rsp_readdata;
                er = rsp_error;
            end
        end
        if (!got) fail_wait("rsp_wait");
    endtask

    initial begin
        int            cc;
        int            lat;
        logic [DW-1:0] rd;
        logic          er;
        logic [DW-1:0] wd;
        bit            ok;
        bit            hold_ok;
        int            hi0;
        logic [DW-1:0] b2b_data [3];

        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        @(posedge clk);
        #1 reset = 1'b1;

        // Zero-wait write
        ack_lat = 1;
        run_cmd(1'b1, 1'b0, 16'h00A5, cc, lat, rd, er, wd);
        chk("wr_cyc_clks", 32'(cc), 32'(1));
        chk("wr_latency", 32'(lat), 32'(2));
        chk("wr_writedata", 32'(wd), 32'h00A5);
        chk("wr_rsp_readdata", 32'(rd), 32'(0));
        chk("wr_rsp_error", 32'(er), 32'(0));

        // Read with ack on the third bus cycle
        ack_lat = 3;
        run_cmd(1'b0, 1'b1, 16'h0000, cc, lat, rd, er, wd);
        chk("rd_cyc_clks", 32'(cc), 32'(3));
        chk("rd_rsp_readdata", 32'(rd), 32'h1234);
        chk("rd_rsp_error", 32'(er), 32'(0));

        // Slave never acks
        ack_lat = 0;
        run_cmd(1'b0, 1'b1, 16'h0000, cc, lat, rd, er, wd);
        chk("to_cyc_clks", 32'(cc), 32'(4));
        chk("to_rsp_error", 32'(er), 32'(1));
        chk("to_rsp_readdata", 32'(rd), 32'(0));

        // Acks with no cycle active are ignored
        @(posedge clk);
        #1 stray_ack = 1'b1;
        hold_ok = 1;
        repeat (3) begin
            @(negedge clk);
            if (wbm_cycle || rsp_valid || !cmd_ready) hold_ok = 0;
        end
        chk("stray_ack_ignored", 32'(hold_ok), 32'(1));
        @(posedge clk);
        #1 stray_ack = 1'b0;

        // Response backpressure with a second command waiting
        ack_lat = 1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_address = 1'b1;
        cmd_writedata = '0;
        wait_accept("bp_accept", ok);
        #1;
        cmd_write = 1'b1;
        cmd_address = 1'b0;
        cmd_writedata = 16'h0077;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1;
        end
        if (!ok) fail_wait("bp_rsp_wait");
        hold_ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (!(rsp_valid && rsp_readdata == 16'h1234 && !rsp_error && !cmd_ready && !wbm_cycle))
                hold_ok = 0;
        end
        chk("bp_hold", 32'(hold_ok), 32'(1));
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_after_hs", 32'(cmd_ready), 32'(1));
        chk("bp_no_cycle_yet", 32'(wbm_cycle), 32'(0));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_cycle", 32'(wbm_cycle), 32'(1));
        chk("bp_second_data", 32'(wbm_writedata), 32'h0077);
        repeat (3) @(negedge clk);
        chk("bp_second_done", 32'(cmd_ready), 32'(1));

        // Asynchronous reset in the middle of a bus cycle
        ack_lat = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_address = 1'b1;
        wait_accept("rst_accept", ok);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_bus_cycle", 32'(wbm_cycle), 32'(1));
        #2 reset = 1'b0;
        #1;
        chk("async_rst_cycle", 32'(wbm_cycle), 32'(0));
        chk("async_rst_strobe", 32'(wbm_strobe), 32'(0));
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));

        // Back-to-back writes to the bar graph
        ack_lat = 1;
        rsp_ready = 1'b1;
        b2b_data[0] = 16'h0001;
        b2b_data[1] = 16'h0002;
        b2b_data[2] = 16'h0004;
        rise_t.delete();
        hi0 = cyc_hi;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_address = 1'b0;
        cmd_writedata = b2b_data[0];
        for (int k = 0; k < 3; k++) begin
            wait_accept("b2b_accept", ok);
            #1;
            if (k < 2) cmd_writedata = b2b_data[k+1];
            else cmd_valid = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("b2b_cycles", 32'(rise_t.size()), 32'(3));
        chk("b2b_cyc_high_clks", 32'(cyc_hi - hi0), 32'(3));
        if (rise_t.size() == 3) begin
            chk("b2b_gap1", 32'(rise_t[1] - rise_t[0]), 32'(3));
            chk("b2b_gap2", 32'(rise_t[2] - rise_t[1]), 32'(3));
        end
        chk("bar_graph", 32'(bar_graph), 32'h04);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic single-transfer initiator; the bus-master end of the peripheral slaves on the BeagleWire fabric (bar graph, etc.).
- Accepts one read/write command at a time on a valid/ready command port and runs exactly one Wishbone cycle.
- Returns read data, or a timeout error, on a valid/ready response port.
- Used by test/bring-up logic to drive Wishbone slaves without the host bridge.

Parameters:
- ADDR_WIDTH, 1, Wishbone address width.
- DATA_WIDTH, 16, Wishbone data width.
- TIMEOUT_CYCLES, 255, maximum bus-phase cycles without ack before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_address  input  ADDR_WIDTH  target address.
- cmd_writedata  input  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_readdata  output  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_error  output  1  1 = transfer aborted by timeout.
- wbm_address  output  ADDR_WIDTH  Wishbone address.
- wbm_writedata  output  DATA_WIDTH  Wishbone write data.
- wbm_readdata  input  DATA_WIDTH  Wishbone read data.
- wbm_strobe  output  1  Wishbone STB.
- wbm_write  output  1  Wishbone WE.
- wbm_cycle  output  1  Wishbone CYC.
- wbm_ack  input  1  Wishbone ACK from the slave.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; cmd_ready=1; rsp_valid=0; rsp_error=0; rsp_readdata=0; wbm_cycle, wbm_strobe, wbm_write=0; wbm_address, wbm_writedata=0; timeout counter=0.
  - Reset asserted mid-transfer drops cycle/strobe immediately, without waiting for a clock edge.
  - Any in-flight command or pending response is discarded.
- FSM states: IDLE, BUS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1: latch write/address/writedata into the Wishbone output registers; set wbm_cycle=wbm_strobe=1, wbm_write=cmd_write; cmd_ready<=0; counter<=0; go to BUS.
- BUS:
  - Address, data, write, cycle and strobe are held stable.
  - On an edge with wbm_ack=1: wbm_cycle, wbm_strobe, wbm_write<=0; rsp_readdata<=wbm_readdata for reads, 0 for writes; rsp_error<=0; rsp_valid<=1; go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: drop cycle/strobe/write; rsp_readdata<=0; rsp_error<=1; rsp_valid<=1; go to RESP.
  - Else counter<=counter+1.
  - Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps when the timeout is disabled.
  - Ack wins over timeout on the same edge.
- RESP:
  - rsp_valid, rsp_readdata and rsp_error are held until an edge with rsp_ready=1.
  - On that edge: rsp_valid<=0; cmd_ready<=1; go to IDLE.
  - An ack arriving while in RESP or IDLE (no cycle active) is ignored.
- Latency with a slave that acks combinationally from CYC:
  - cycle/strobe are high for exactly 1 clock.
  - rsp_valid rises 2 edges after command acceptance.
  - Minimum 3 clocks per transaction with rsp_ready tied high.
- Commands presented while cmd_ready=0 are not accepted; the command source holds them.

Test Plan:
- Write to a zero-wait slave: cmd write addr=0 data=16'h00A5 -> cyc/stb/we high for exactly 1 clk with wbm_writedata=16'h00A5; then rsp_valid=1, rsp_error=0, rsp_readdata=0.
- Read with 3-cycle ack delay: slave returns 16'h1234 with ack on the 3rd bus cycle -> cyc held exactly 3 clks; rsp_readdata=16'h1234, rsp_error=0.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> cyc high for exactly 4 clks then drops; rsp_valid=1, rsp_error=1, rsp_readdata=0.
- Response backpressure: rsp_ready low for 5 clks, cmd_valid held high -> rsp held stable, cmd_ready=0 for all 5 clks; second command accepted only after the rsp handshake.
- Async reset mid-BUS: assert reset between edges while cyc=1 -> cyc/stb=0 immediately; after release cmd_ready=1, rsp_valid=0.
- Back-to-back writes 8'h01, 8'h02, 8'h04 to the bar graph slave with rsp_ready=1 -> three 1-clk cycles spaced 3 clks apart, final bar_graph=8'h04.
